// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store sequencer: op codes, FSM states and
// the default data-memory depth.
package mem_access_pkg;

  localparam int DEPTH_WORDS_DEFAULT = 128;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Loads occupy the low five op codes; everything above is a store.
  function automatic logic is_load(input logic [2:0] op);
    return (op <= OP_LBU);
  endfunction

endpackage

// File: rtl/mem_access_unit_load_store_align.sv
// Combinational lane logic: little-endian byte/half extraction with sign or
// zero extension, sub-word merge for read-modify-write stores, and the
// alignment check for the requested op.
module load_store_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] store_data,
  output logic [31:0] load_value,
  output logic [31:0] merged_word,
  output logic        misaligned
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte and halfword out of the memory word.
  always_comb begin
    sel_byte = 8'h00;
    sel_half = (lane[1] == 1'b1) ? word[31:16] : word[15:0];
    case (lane)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      2'd3:    sel_byte = word[31:24];
      default: sel_byte = word[7:0];
    endcase
  end

  // Extend the selected lane to a full word according to the load type.
  always_comb begin
    load_value = word;
    case (op)
      OP_LW:   load_value = word;
      OP_LH:   load_value = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_value = {16'h0000, sel_half};
      OP_LB:   load_value = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_value = {24'h000000, sel_byte};
      default: load_value = word;
    endcase
  end

  // Overlay the store lane onto the captured word; full-word stores pass through.
  always_comb begin
    merged_word = store_data;
    case (op)
      OP_SB: begin
        merged_word = word;
        case (lane)
          2'd0:    merged_word[7:0]   = store_data[7:0];
          2'd1:    merged_word[15:8]  = store_data[7:0];
          2'd2:    merged_word[23:16] = store_data[7:0];
          2'd3:    merged_word[31:24] = store_data[7:0];
          default: merged_word[7:0]   = store_data[7:0];
        endcase
      end
      OP_SH: begin
        merged_word = word;
        if (lane[1] == 1'b1) begin
          merged_word[31:16] = store_data[15:0];
        end else begin
          merged_word[15:0] = store_data[15:0];
        end
      end
      default: merged_word = store_data;
    endcase
  end

  // Words need both low address bits clear, halfwords need bit 0 clear.
  always_comb begin
    misaligned = 1'b0;
    case (op)
      OP_LW, OP_SW:         misaligned = (lane != 2'd0);
      OP_LH, OP_LHU, OP_SH: misaligned = lane[0];
      default:              misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store sequencer in front of a word-addressed data memory.
// One request at a time; sub-word stores use read-modify-write. All outputs
// are registered.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  logic [1:0]  state;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [31:0] store_q;

  logic [2:0]  al_op;
  logic [1:0]  al_lane;
  logic [31:0] al_store;
  logic [31:0] load_value;
  logic [31:0] merged_word;
  logic        misaligned;
  logic        out_of_range;

  // In IDLE the aligner checks the incoming request; afterwards it works on the latched one.
  always_comb begin
    if (state == ST_IDLE) begin
      al_op    = op;
      al_lane  = addr[1:0];
      al_store = store_data;
    end else begin
      al_op    = op_q;
      al_lane  = lane_q;
      al_store = store_q;
    end
  end

  // Range check against the memory size in bytes.
  always_comb begin
    out_of_range = ({1'b0, addr} >= ADDR_LIMIT);
  end

  load_store_align u_align (
    .op          (al_op),
    .lane        (al_lane),
    .word        (mem_read_data),
    .store_data  (al_store),
    .load_value  (load_value),
    .merged_word (merged_word),
    .misaligned  (misaligned)
  );

  // Sequencer FSM; strobes default low so each is a single-cycle pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      op_q           <= 3'd0;
      lane_q         <= 2'd0;
      store_q        <= 32'h0000_0000;
      load_data      <= 32'h0000_0000;
      busy           <= 1'b0;
      done           <= 1'b0;
      fault          <= 1'b0;
      mem_address    <= 32'h0000_0000;
      mem_write_data <= 32'h0000_0000;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
    end else begin
      done      <= 1'b0;
      fault     <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            lane_q  <= addr[1:0];
            store_q <= store_data;
            busy    <= 1'b1;
            if (misaligned || out_of_range) begin
              // Illegal access: report straight away, memory untouched.
              state <= ST_DONE;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              mem_address <= {addr[31:2], 2'b00};
              if (op == OP_SW) begin
                state          <= ST_WRITE;
                mem_write      <= 1'b1;
                mem_write_data <= merged_word;
              end else begin
                state    <= ST_READ;
                mem_read <= 1'b1;
              end
            end
          end
        end
        ST_READ: begin
          if (is_load(op_q)) begin
            state     <= ST_DONE;
            done      <= 1'b1;
            load_data <= load_value;
          end else begin
            // Sub-word store: merge into the word just read, then write it back.
            state          <= ST_WRITE;
            mem_write      <= 1'b1;
            mem_write_data <= merged_word;
          end
        end
        ST_WRITE: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural data memory and a
// scoreboard queue of expected load_data/fault per request.
module tb_mem_access_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  int total = 0;
  int bad   = 0;

  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  int done_cnt = 0;
  logic [31:0] last_wdata = 32'h0;

  logic [31:0] mem [0:127] = '{0: 32'h8899AABB, 1: 32'h12345678, 3: 32'h11112222, default: 32'h0};

  typedef struct {
    logic [31:0] ld;
    logic        flt;
  } exp_t;
  exp_t sbq[$];

  mem_access_unit #(.DEPTH_WORDS(128)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .op             (op),
    .addr           (addr),
    .store_data     (store_data),
    .load_data      (load_data),
    .busy           (busy),
    .done           (done),
    .fault          (fault),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_read_data = mem[mem_address[8:2]];

  // Memory commits on the falling edge; strobe activity is tallied at the same point.
  always @(negedge clock) begin
    if (mem_write) begin
      mem[mem_address[8:2]] <= mem_write_data;
      wr_cnt     <= wr_cnt + 1;
      last_wdata <= mem_write_data;
    end
    if (mem_read)             rd_cnt   <= rd_cnt + 1;
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
    if (done)                 done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request (called #1 after a posedge) and check it end to end.
  task automatic issue(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] d, input int exp_lat, input logic [31:0] exp_ld,
                       input logic exp_flt, input int exp_rd, input int exp_wr,
                       input logic hold);
    int   cycles;
    int   rd0;
    int   wr0;
    exp_t e;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    op = o; addr = a; store_data = d; start = 1'b1;
    sbq.push_back('{ld: exp_ld, flt: exp_flt});
    @(posedge clock); #1;
    if (!hold) start = 1'b0;
    // Perturb inputs after the sampling edge; they must have no effect.
    addr = 32'h0000_0010; store_data = 32'h5A5A_5A5A; op = 3'd6;
    cycles = 1;
    chk({tag, "_busy"}, {31'h0, busy}, 32'h1);
    while (!done && cycles < 8) begin
      @(posedge clock); #1;
      cycles++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, cycles, exp_lat);
    e = sbq.pop_front();
    chk({tag, "_load_data"}, load_data, e.ld);
    chk({tag, "_fault"}, {31'h0, fault}, {31'h0, e.flt});
    chk({tag, "_reads"}, rd_cnt - rd0, exp_rd);
    chk({tag, "_writes"}, wr_cnt - wr0, exp_wr);
    @(posedge clock); #1;
    chk({tag, "_idle"}, {30'h0, busy, done}, 32'h0);
  endtask

  initial begin
    int wr_before;
    int done_before;
    reset = 1'b1; start = 1'b0; op = 3'd0; addr = 32'h0; store_data = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outs", {28'h0, busy, done, fault, mem_read}, 32'h0);
    chk("reset_wr", {31'h0, mem_write}, 32'h0);
    chk("reset_ld", load_data, 32'h0);
    chk("reset_addr", mem_address, 32'h0);
    chk("reset_wdata", mem_write_data, 32'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    issue("lb",  3'd3, 32'h1, 32'h0, 2, 32'hFFFFFFAA, 1'b0, 1, 0, 1'b0);
    issue("lbu", 3'd4, 32'h1, 32'h0, 2, 32'h000000AA, 1'b0, 1, 0, 1'b0);
    issue("lh",  3'd1, 32'h6, 32'h0, 2, 32'h00001234, 1'b0, 1, 0, 1'b0);
    issue("lw",  3'd0, 32'h4, 32'h0, 2, 32'h12345678, 1'b0, 1, 0, 1'b0);
    issue("sb",  3'd7, 32'h2, 32'h000000CC, 3, 32'h12345678, 1'b0, 1, 1, 1'b0);
    chk("sb_wdata", last_wdata, 32'h88CCAABB);
    issue("lw0", 3'd0, 32'h0, 32'h0, 2, 32'h88CCAABB, 1'b0, 1, 0, 1'b0);
    issue("lh_neg", 3'd1, 32'h2, 32'h0, 2, 32'hFFFF88CC, 1'b0, 1, 0, 1'b0);
    issue("lw_mis", 3'd0, 32'h3, 32'h0, 1, 32'hFFFF88CC, 1'b1, 0, 0, 1'b0);
    issue("lh_mis", 3'd1, 32'h5, 32'h0, 1, 32'hFFFF88CC, 1'b1, 0, 0, 1'b0);
    issue("sw_oor", 3'd5, 32'h200, 32'h11111111, 1, 32'hFFFF88CC, 1'b1, 0, 0, 1'b0);

    done_before = done_cnt;
    issue("sw_hold", 3'd5, 32'h8, 32'hDEADBEEF, 2, 32'hFFFF88CC, 1'b0, 0, 1, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    chk("sw_hold_one_done", done_cnt - done_before, 32'd1);
    chk("sw_hold_mem", mem[2], 32'hDEADBEEF);
    issue("lw8", 3'd0, 32'h8, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1, 0, 1'b0);

    issue("sh", 3'd6, 32'hE, 32'h1234BEEF, 3, 32'hDEADBEEF, 1'b0, 1, 1, 1'b0);
    issue("lwc", 3'd0, 32'hC, 32'h0, 2, 32'hBEEF2222, 1'b0, 1, 0, 1'b0);
    issue("lhu_hi", 3'd2, 32'hE, 32'h0, 2, 32'h0000BEEF, 1'b0, 1, 0, 1'b0);

    // Reset while an SH is in its read cycle.
    wr_before = wr_cnt;
    op = 3'd6; addr = 32'hC; store_data = 32'h00007777; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("rst_mid_read", {31'h0, mem_read}, 32'h1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_mid_outs", {28'h0, busy, done, fault, mem_read}, 32'h0);
    chk("rst_mid_wr", {31'h0, mem_write}, 32'h0);
    chk("rst_mid_ld", load_data, 32'h0);
    chk("rst_mid_addr", mem_address, 32'h0);
    chk("rst_mid_wdata", mem_write_data, 32'h0);
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("rst_mid_no_write", wr_cnt - wr_before, 32'd0);
    chk("rst_mid_mem", mem[3], 32'hBEEF2222);
    chk("rd_wr_exclusive", both_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multi-cycle load/store sequencer sitting directly upstream of the word-addressed data memory in the multi-cycle datapath.
- Accepts one load/store request at a time from the control FSM and drives the memory's address, writeData, memWrite and memRead.
- Supports sub-word loads with sign/zero extension and sub-word stores via read-modify-write.
- Returns formatted load data with a done pulse; flags misaligned or out-of-range accesses without touching memory.

Parameters:
- DEPTH_WORDS, 128, number of 32-bit words in the data memory; byte addresses >= 4*DEPTH_WORDS fault.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  3  0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB.
- addr  input  32  byte address of the access.
- store_data  input  32  store source; low byte/half used for SB/SH.
- load_data  output  32  extended load result; held until next load completes.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle completion pulse.
- fault  output  1  valid with done; 1 = misaligned or out-of-range, no memory access made.
- mem_address  output  32  word-aligned byte address {addr[31:2],2'b00}.
- mem_write_data  output  32  full word to write.
- mem_write  output  1  memory write enable; memory commits on the negedge inside the cycle.
- mem_read  output  1  memory read enable.
- mem_read_data  input  32  combinational read data from memory.

Behaviour:
- Reset: state IDLE. load_data, done, busy, fault, mem_read, mem_write, mem_address and mem_write_data are all 0.
- All outputs are registered (Moore); no input-to-output combinational path.
- States: IDLE, READ, WRITE, DONE.
- IDLE, start=1, legality check:
  - Misaligned (LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]=1) or out of range -> DONE with fault=1.
  - Otherwise mem_address is latched. LW/LH/LHU/LB/LBU/SH/SB -> READ. SW -> WRITE.
- READ:
  - mem_read=1 for exactly one cycle.
  - At the closing posedge mem_read_data is captured.
  - Loads -> DONE. SH/SB -> WRITE.
- WRITE:
  - mem_write=1 for exactly one cycle. SW writes store_data as latched at start.
  - SB/SH merge the selected lane into the captured word, preserving the other bytes. Merged data is registered on entry to WRITE.
  - -> DONE.
- DONE:
  - done=1 for one cycle; fault is valid; load_data is updated on entry to DONE for loads.
  - -> IDLE.
- Lane mapping is little-endian: byte k = bits [8k+7:8k] selected by addr[1:0]; halfword selected by addr[1] (bits [15:0] or [31:16]).
- Extension: LB/LH sign-extend; LBU/LHU zero-extend.
- Latency (posedges after the start-sampling edge until done is high):
  - LW/LH/LHU/LB/LBU: 2
  - SW: 2
  - SH/SB: 3
  - Faulting access: 1
- start while busy is ignored; no queuing.
- op, addr and store_data are latched at start; later changes have no effect.
- Reset mid-operation takes effect at the next posedge. A WRITE cycle already in progress commits at its negedge; no further memory strobes follow.
- load_data is unchanged by stores and faulting accesses.
- mem_read and mem_write are never both high. Both are 0 in IDLE and DONE.

Decomposition:
- Package mem_access_pkg holds:
  - the op encodings (localparams OP_LW..OP_SB)
  - the state encoding (IDLE/READ/WRITE/DONE)
  - DEPTH_WORDS default
- One combinational sub-module, load_store_align:
  - inputs: op, addr[1:0], word, store_data
  - outputs: extended load value, merged store word, misaligned flag

Test Plan:
- Memory word0=0x8899AABB, LB addr=0x1 -> done 2 cycles after start, load_data=0xFFFFFFAA, fault=0. Repeat with LBU -> 0x000000AA.
- word1=0x12345678, LH addr=0x6 -> load_data=0x00001234. LW addr=0x4 -> load_data=0x12345678.
- SB addr=0x2 store_data=0x000000CC over word0=0x8899AABB -> mem_read 1 cycle, then mem_write 1 cycle with 0x88CCAABB; done 3 cycles after start; LW addr=0x0 then returns 0x88CCAABB.
- LW addr=0x3 -> done+fault 1 cycle after start, mem_read and mem_write never asserted, load_data unchanged. Repeat with SW addr=0x200 (out of range at DEPTH_WORDS=128) -> fault.
- SW addr=0x8 data=0xDEADBEEF with start held high and a second start during busy -> exactly one write, one done pulse; LW addr=0x8 returns 0xDEADBEEF.
- Assert reset during READ of an SH -> next cycle IDLE with all outputs 0, no mem_write ever asserted, target word unchanged.
